// File: rtl/pulse_receiver.sv
// -----------------------------------------------------------------------------
// pulse_receiver
//
// Deserialises an MSB-first pulse stream into WIDTH-bit frames. A frame begins
// on the cycle that frame_start is high (that cycle carries the MSB) and spans
// WIDTH consecutive cycles. The completed word is delivered one edge after the
// last bit is sampled, so data_valid is high during the cycle after edge
// N+WIDTH when frame_start was sampled at edge N.
//
// Optional feature: macro PULSE_RX_ONES_COUNT_EN enables a running popcount
// that is delivered on ones_count together with data_out. With the macro
// undefined the counter logic is absent and ones_count is tied to zero.
//
// Parameters
//   WIDTH        frame length in bits (2..31, ones_count is 5 bits wide)
//
// Ports
//   clock        single clock, all state updates on the rising edge
//   reset        synchronous, active-high reset; wins over frame_start
//   serial_in    serial pulse stream, sampled on every rising edge
//   frame_start  high on the cycle carrying the first (MSB) bit of a frame
//   data_out     last completed frame; changes only when data_valid rises
//   data_valid   one-cycle strobe marking a data_out update
//   busy         high while a frame is being received
//   ones_count   number of 1 bits in the last completed frame
// -----------------------------------------------------------------------------
module pulse_receiver #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic [4:0]       ones_count
);

    localparam int CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int SHIFT_W = WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH - 2);

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    // Holds the WIDTH-1 bits received so far; the final bit is taken straight
    // from serial_in when the word is completed, so no MSB slot is wasted.
    logic [SHIFT_W-1:0] shift_q, shift_d;
    // Completed word parked for one cycle until it is delivered; this keeps a
    // new frame starting on the delivery edge from disturbing it.
    logic [WIDTH-1:0]   word_q, word_d;
    logic               pending_q, pending_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;

    logic               start_frame;
    logic               frame_done;
    logic [WIDTH-1:0]   next_word;

`ifdef PULSE_RX_ONES_COUNT_EN
    logic [4:0]         ones_run_q, ones_run_d;
    logic [4:0]         ones_word_q, ones_word_d;
    logic [4:0]         ones_count_q, ones_count_d;
`endif

    // A frame_start in either state (re)starts reception; in RECEIVE this
    // aborts the partial frame, which therefore never reaches frame_done.
    assign start_frame = frame_start;
    assign frame_done  = (state_q == RECEIVE) && !frame_start && (bit_cnt_q == '0);
    assign next_word   = {shift_q, serial_in};

    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        pending_d    = frame_done;
        data_valid_d = pending_q;
        data_out_d   = data_out_q;

        if (frame_done) begin
            word_d = next_word;
        end

        // Delivery happens one edge after the last bit, independent of
        // whatever the receive FSM is doing on that edge.
        if (pending_q) begin
            data_out_d = word_q;
        end

        unique case (state_q)
            IDLE: begin
                if (start_frame) begin
                    state_d   = RECEIVE;
                    shift_d   = SHIFT_W'(serial_in);
                    bit_cnt_d = CNT_START;
                end
            end
            RECEIVE: begin
                if (start_frame) begin
                    shift_d   = SHIFT_W'(serial_in);
                    bit_cnt_d = CNT_START;
                end else if (bit_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    shift_d   = next_word[SHIFT_W-1:0];
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PULSE_RX_ONES_COUNT_EN
    // Running popcount follows the same start/restart rules as the shifter.
    always_comb begin
        ones_run_d   = ones_run_q;
        ones_word_d  = ones_word_q;
        ones_count_d = ones_count_q;

        if (start_frame) begin
            ones_run_d = {4'b0, serial_in};
        end else if (state_q == RECEIVE) begin
            ones_run_d = ones_run_q + {4'b0, serial_in};
        end

        if (frame_done) begin
            ones_word_d = ones_run_q + {4'b0, serial_in};
        end

        if (pending_q) begin
            ones_count_d = ones_word_q;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            pending_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
`ifdef PULSE_RX_ONES_COUNT_EN
            ones_run_q   <= '0;
            ones_word_q  <= '0;
            ones_count_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            pending_q    <= pending_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
`ifdef PULSE_RX_ONES_COUNT_EN
            ones_run_q   <= ones_run_d;
            ones_word_q  <= ones_word_d;
            ones_count_q <= ones_count_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q == RECEIVE);

`ifdef PULSE_RX_ONES_COUNT_EN
    assign ones_count = ones_count_q;
`else
    assign ones_count = 5'd0;
`endif

endmodule

// File: tb/tb_pulse_receiver.sv
// -----------------------------------------------------------------------------
// tb_pulse_receiver
//
// Self-checking bench for pulse_receiver (WIDTH = 16). Frames are driven MSB
// first; each frame that should complete pushes its expected word, ones count
// and delivery cycle into a scoreboard, and a monitor pops and compares on
// every data_valid strobe. Between strobes the monitor requires data_out to
// hold. Honours PULSE_RX_ONES_COUNT_EN for the expected ones_count.
// -----------------------------------------------------------------------------
module tb_pulse_receiver;

    localparam int W = 16;

    logic         clock       = 1'b0;
    logic         reset       = 1'b0;
    logic         serial_in   = 1'b0;
    logic         frame_start = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic [4:0]   ones_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [4:0]   ones;
        int           at;
    } exp_t;

    exp_t sb[$];

    pulse_receiver #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .serial_in   (serial_in),
        .frame_start (frame_start),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .ones_count  (ones_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4:0] exp_ones(input logic [W-1:0] w);
`ifdef PULSE_RX_ONES_COUNT_EN
        return 5'($countones(w));
`else
        return (w == '0) ? 5'd0 : 5'd0;
`endif
    endfunction

    // Inputs change 1 time unit after the rising edge and are sampled on the
    // next one; cyc then equals the number of edges already seen.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_expect(input logic [W-1:0] w);
        exp_t e;
        e.data = w;
        e.ones = exp_ones(w);
        e.at   = cyc + 1 + W;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit expect_it);
        for (int i = W - 1; i >= 0; i--) begin
            tick();
            frame_start = (i == W - 1);
            serial_in   = w[i];
            if (i == W - 1 && expect_it) push_expect(w);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            frame_start = 1'b0;
            serial_in   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3 * W) begin
            tick();
            frame_start = 1'b0;
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d frames still outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic monitor_loop();
        logic [W-1:0] prev_out;
        logic         prev_rst;
        exp_t         e;
        prev_out = data_out;
        prev_rst = 1'b1;
        forever begin
            @(negedge clock);
            if (data_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: strobe with data_out=%h at cycle %0d, required none",
                             data_out, cyc);
                end else begin
                    e = sb.pop_front();
                    total++;
                    if (data_out !== e.data) begin
                        bad++;
                        $display("FAIL data_out: got %h, required %h", data_out, e.data);
                    end
                    total++;
                    if (ones_count !== e.ones) begin
                        bad++;
                        $display("FAIL ones_count: got %0d, required %0d", ones_count, e.ones);
                    end
                    total++;
                    if (cyc != e.at) begin
                        bad++;
                        $display("FAIL latency: strobe at cycle %0d, required %0d", cyc, e.at);
                    end
                end
            end else if (!prev_rst) begin
                total++;
                if (data_out !== prev_out) begin
                    bad++;
                    $display("FAIL data_hold: data_out changed to %h from %h without data_valid",
                             data_out, prev_out);
                end
            end
            prev_out = data_out;
            prev_rst = reset;
        end
    endtask

    task automatic test_reset();
        // Reset asserted together with frame_start: reset must win.
        tick();
        reset       = 1'b1;
        frame_start = 1'b1;
        serial_in   = 1'b1;
        tick();
        reset       = 1'b0;
        frame_start = 1'b0;
        total++;
        if (data_out !== '0) begin
            bad++;
            $display("FAIL reset_data_out: got %h, required 0", data_out);
        end
        total++;
        if (data_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_data_valid: got %b, required 0", data_valid);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        total++;
        if (ones_count !== 5'd0) begin
            bad++;
            $display("FAIL reset_ones_count: got %0d, required 0", ones_count);
        end
        idle(4);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_single();
        send_frame(16'h5254, 1'b1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_busy_mid: got %b, required 1", busy);
        end
        idle(4);
        wait_drain("single");
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_after: got %b, required 0", busy);
        end
    endtask

    task automatic test_idle_noise();
        logic [W-1:0] held;
        held = data_out;
        for (int i = 0; i < 50; i++) begin
            tick();
            frame_start = 1'b0;
            serial_in   = ~serial_in;
            total++;
            if (busy !== 1'b0 || data_valid !== 1'b0 || data_out !== held) begin
                bad++;
                $display("FAIL idle_noise: busy=%b valid=%b data_out=%h, required 0 0 %h",
                         busy, data_valid, data_out, held);
            end
        end
    endtask

    task automatic test_back_to_back();
        send_frame(16'hFFFF, 1'b1);
        send_frame(16'h0000, 1'b1);
        send_frame(16'h8001, 1'b1);
        idle(2);
        wait_drain("back_to_back");
    endtask

    task automatic test_start_on_valid();
        // Second frame_start lands in the cycle where the first strobe is high.
        send_frame(16'hC3A5, 1'b1);
        idle(1);
        send_frame(16'h0F0F, 1'b1);
        idle(2);
        wait_drain("start_on_valid");
    endtask

    task automatic test_abort();
        logic [W-1:0] junk;
        junk = 16'hAAAA;
        for (int i = W - 1; i >= 9; i--) begin
            tick();
            frame_start = (i == W - 1);
            serial_in   = junk[i];
        end
        send_frame(16'h1234, 1'b1);
        idle(2);
        wait_drain("abort");
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] junk;
        junk = 16'hBEEF;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = W - 1; i >= 6; i--) begin
            tick();
            frame_start = (i == W - 1);
            serial_in   = junk[i];
        end
        tick();
        frame_start = 1'b0;
        serial_in   = junk[5];
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_busy: got %b, required 0", busy);
        end
        idle(W + 6);
        total++;
        if (data_out !== '0) begin
            bad++;
            $display("FAIL reset_mid_data_out: got %h, required 0", data_out);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_busy_late: got %b, required 0", busy);
        end
    endtask

    // Behaves like pulse_generator: a loaded word shifted out MSB first with
    // frame_start marking the first bit.
    task automatic test_loopback();
        logic [W-1:0] sh;
        sh = 16'h5254;
        for (int k = 0; k < W; k++) begin
            tick();
            frame_start = (k == 0);
            serial_in   = sh[W-1];
            if (k == 0) push_expect(sh);
            sh = sh << 1;
        end
        idle(3);
        wait_drain("loopback");
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_single();
        test_idle_noise();
        test_back_to_back();
        test_start_on_valid();
        test_abort();
        test_reset_mid();
        test_loopback();
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
